// File: rtl/vga_text_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : vga_text_renderer
//  Purpose  : 80x30 character text-mode renderer for 640x480@60 Hz VGA.
//             Scans the screen, fetches character codes from a synchronous
//             text buffer and glyph rows from a combinational font ROM. It
//             serialises glyph rows into pixels and overlays a blinking
//             underline cursor.
//  Ports    :
//    clk            pixel clock (25 MHz nominal)
//    reset          asynchronous, active-high
//    io_cursor_x    cursor column 0..79 (out-of-range disables the cursor)
//    io_cursor_y    cursor row 0..29 (out-of-range disables the cursor)
//    io_cursor_en   cursor enable
//    io_text_addr   text buffer address row*80+col (0 outside visible area)
//    io_text_data   character code, valid one cycle after io_text_addr
//    io_font_addr   font ROM address {char, glyph_row}
//    io_font_data   glyph row, combinational, bit 7 = leftmost pixel
//    io_vga_hs/vs   sync outputs, active low
//    io_vga_r/g/b   RGB444 colour
//    io_frame_start one-cycle pulse with the first visible pixel of a frame
//  Revision : 1.0  initial release
// ============================================================================
module vga_text_renderer #(
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  io_cursor_x,
  input  logic [4:0]  io_cursor_y,
  input  logic        io_cursor_en,
  output logic [11:0] io_text_addr,
  input  logic [7:0]  io_text_data,
  output logic [11:0] io_font_addr,
  input  logic [7:0]  io_font_data,
  output logic        io_vga_hs,
  output logic        io_vga_vs,
  output logic [3:0]  io_vga_r,
  output logic [3:0]  io_vga_g,
  output logic [3:0]  io_vga_b,
  output logic        io_frame_start
);

  localparam logic [9:0] H_LAST     = 10'd799;
  localparam logic [9:0] V_LAST     = 10'd524;
  localparam logic [9:0] H_VISIBLE  = 10'd640;
  localparam logic [9:0] V_VISIBLE  = 10'd480;
  localparam logic [9:0] HS_START   = 10'd656;
  localparam logic [9:0] HS_END     = 10'd751;
  localparam logic [9:0] VS_START   = 10'd490;
  localparam logic [9:0] VS_END     = 10'd491;
  localparam int         FRAME_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  // --------------------------------------------------------------------------
  // S0: scan counters and blink state
  // --------------------------------------------------------------------------
  logic               run;          // low for the first edge after reset
  logic [9:0]         h_cnt;
  logic [9:0]         v_cnt;
  logic [FRAME_W-1:0] frame_cnt;
  logic               blink_phase;

  logic               h_last;
  logic               v_last;
  logic               visible;
  logic               hs_s0;
  logic               vs_s0;
  logic [6:0]         cell_col;
  logic [4:0]         cell_row;
  logic [11:0]        row_base;
  logic               cursor_hit;

  assign h_last   = (h_cnt == H_LAST);
  assign v_last   = (v_cnt == V_LAST);
  assign visible  = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE);
  assign hs_s0    = !((h_cnt >= HS_START) && (h_cnt <= HS_END));
  assign vs_s0    = !((v_cnt >= VS_START) && (v_cnt <= VS_END));
  assign cell_col = h_cnt[9:3];
  // Only meaningful inside the visible area, where v < 480 keeps the row < 30.
  assign cell_row = v_cnt[8:4];

  // row*80 as row*64 + row*16; peaks at 29*80 + 79 = 2399.
  assign row_base     = {1'b0, cell_row, 6'b0} + {3'b0, cell_row, 4'b0};
  assign io_text_addr = visible ? (row_base + {5'b0, cell_col}) : 12'd0;

  // Underline on glyph rows 14 and 15 of the cursor cell. The range checks
  // keep out-of-range cursor positions from matching a blanking-area cell.
  assign cursor_hit = io_cursor_en && blink_phase && visible &&
                      (io_cursor_x < 7'd80) && (io_cursor_y < 5'd30) &&
                      (cell_col == io_cursor_x) && (cell_row == io_cursor_y) &&
                      (v_cnt[3:1] == 3'b111);

  // The first edge after reset only arms 'run', so h=0,v=0 is presented for
  // a full cycle before the scan starts advancing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run         <= 1'b0;
      h_cnt       <= 10'd0;
      v_cnt       <= 10'd0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run) begin
        if (h_last) begin
          h_cnt <= 10'd0;
          if (v_last) begin
            v_cnt <= 10'd0;
            if (frame_cnt == FRAME_LAST) begin
              frame_cnt   <= '0;
              blink_phase <= ~blink_phase;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end else begin
            v_cnt <= v_cnt + 10'd1;
          end
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // S1: delayed scan position; character code arrives from the text buffer
  // --------------------------------------------------------------------------
  logic [2:0] h_d1;
  logic [3:0] v_d1;
  logic       visible_d1;
  logic       hs_d1;
  logic       vs_d1;
  logic       hit_d1;
  logic       start_d1;
  logic       pixel;

  // Held in reset state until the scan runs so the first pixel is not doubled.
  // Sync stages reset to their inactive (high) level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_d1       <= 3'd0;
      v_d1       <= 4'd0;
      visible_d1 <= 1'b0;
      hs_d1      <= 1'b1;
      vs_d1      <= 1'b1;
      hit_d1     <= 1'b0;
      start_d1   <= 1'b0;
    end else if (run) begin
      h_d1       <= h_cnt[2:0];
      v_d1       <= v_cnt[3:0];
      visible_d1 <= visible;
      hs_d1      <= hs_s0;
      vs_d1      <= vs_s0;
      hit_d1     <= cursor_hit;
      start_d1   <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end
  end

  assign io_font_addr = {io_text_data, v_d1};
  assign pixel        = io_font_data[3'd7 - h_d1] ^ hit_d1;

  // --------------------------------------------------------------------------
  // S2: registered pins
  // --------------------------------------------------------------------------
  logic [11:0] rgb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb            <= 12'h000;
      io_vga_hs      <= 1'b1;
      io_vga_vs      <= 1'b1;
      io_frame_start <= 1'b0;
    end else begin
      if (visible_d1) begin
        rgb <= pixel ? FG_COLOR : BG_COLOR;
      end else begin
        rgb <= 12'h000;
      end
      io_vga_hs      <= hs_d1;
      io_vga_vs      <= vs_d1;
      io_frame_start <= start_d1;
    end
  end

  assign io_vga_r = rgb[11:8];
  assign io_vga_g = rgb[7:4];
  assign io_vga_b = rgb[3:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_text_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_text_renderer
//  Purpose  : Directed self-checking bench for vga_text_renderer. Uses a
//             synchronous text buffer model and a one-glyph font model, and
//             repositions the scan counters to reach distant screen positions
//             within a short run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_text_renderer;

  localparam logic [11:0] FG = 12'hFA5;
  localparam logic [11:0] BG = 12'h123;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  cursor_x = 7'd0;
  logic [4:0]  cursor_y = 5'd0;
  logic        cursor_en = 1'b0;
  logic [11:0] text_addr;
  logic [7:0]  text_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic        vga_hs;
  logic        vga_vs;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        frame_start;
  logic [11:0] rgb;

  logic [7:0]  text_mem [0:4095];

  int total = 0;
  int bad   = 0;

  vga_text_renderer #(
    .FG_COLOR     (FG),
    .BG_COLOR     (BG),
    .BLINK_FRAMES (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .io_cursor_x    (cursor_x),
    .io_cursor_y    (cursor_y),
    .io_cursor_en   (cursor_en),
    .io_text_addr   (text_addr),
    .io_text_data   (text_data),
    .io_font_addr   (font_addr),
    .io_font_data   (font_data),
    .io_vga_hs      (vga_hs),
    .io_vga_vs      (vga_vs),
    .io_vga_r       (vga_r),
    .io_vga_g       (vga_g),
    .io_vga_b       (vga_b),
    .io_frame_start (frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) text_data <= text_mem[text_addr];

  // Only 'A' glyph row 3 is non-blank: 1000_0001.
  assign font_data = (font_addr == 12'h413) ? 8'h81 : 8'h00;
  assign rgb       = {vga_r, vga_g, vga_b};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Moves the scan position; the next edge advances from (h, v).
  task automatic jump(input int h, input int v);
    dut.h_cnt = 10'(h);
    dut.v_cnt = 10'(v);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick(); tick();
    total++; if (vga_hs !== 1'b1) begin bad++; $display("FAIL reset_hs got=%b want=1", vga_hs); end
    total++; if (vga_vs !== 1'b1) begin bad++; $display("FAIL reset_vs got=%b want=1", vga_vs); end
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%h want=000", rgb); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b want=0", frame_start); end
    total++; if (text_addr !== 12'd0) begin bad++; $display("FAIL reset_text_addr got=%0d want=0", text_addr); end
    total++; if (font_addr !== 12'h5A0) begin bad++; $display("FAIL reset_font_addr got=%h want=5a0", font_addr); end
  endtask

  // From release: pin at edge n shows scan index n-3.
  task automatic test_sync_timing();
    int first_hs = -1;
    int hs_low = 0;
    int vs_low = 0;
    int fs_cnt = 0;
    int fs_at = -1;
    reset = 1'b0;
    for (int n = 1; n <= 1600; n++) begin
      tick();
      if (vga_hs === 1'b0) begin
        hs_low++;
        if (first_hs < 0) first_hs = n;
      end
      if (vga_vs === 1'b0) vs_low++;
      if (frame_start === 1'b1) begin fs_cnt++; fs_at = n; end
    end
    total++; if (first_hs != 659) begin bad++; $display("FAIL hs_first_edge got=%0d want=659", first_hs); end
    total++; if (hs_low != 192) begin bad++; $display("FAIL hs_low_two_lines got=%0d want=192", hs_low); end
    total++; if (vs_low != 0) begin bad++; $display("FAIL vs_idle got=%0d want=0", vs_low); end
    total++; if (fs_cnt != 1) begin bad++; $display("FAIL fs_count got=%0d want=1", fs_cnt); end
    total++; if (fs_at != 3) begin bad++; $display("FAIL fs_edge got=%0d want=3", fs_at); end
  endtask

  task automatic test_addressing();
    jump(639, 479); #1;
    total++; if (text_addr !== 12'd2399) begin bad++; $display("FAIL addr_639_479 got=%0d want=2399", text_addr); end
    tick();
    total++; if (text_addr !== 12'd0) begin bad++; $display("FAIL addr_640_479 got=%0d want=0", text_addr); end
    jump(799, 479); #1;
    total++; if (text_addr !== 12'd0) begin bad++; $display("FAIL addr_799_479 got=%0d want=0", text_addr); end
    jump(15, 16); #1;
    total++; if (text_addr !== 12'd81) begin bad++; $display("FAIL addr_15_16 got=%0d want=81", text_addr); end
    jump(200, 100); #1;
    total++; if (text_addr !== 12'd505) begin bad++; $display("FAIL addr_200_100 got=%0d want=505", text_addr); end
  endtask

  // Pin at edge k after a jump shows scan index start+k-2.
  task automatic test_vsync();
    int vs_low = 0;
    int first_vs = -1;
    jump(790, 489);
    for (int k = 1; k <= 1800; k++) begin
      tick();
      if (vga_vs === 1'b0) begin
        vs_low++;
        if (first_vs < 0) first_vs = k;
      end
    end
    total++; if (vs_low != 1600) begin bad++; $display("FAIL vs_low_frame got=%0d want=1600", vs_low); end
    total++; if (first_vs != 12) begin bad++; $display("FAIL vs_first_edge got=%0d want=12", first_vs); end
  endtask

  task automatic test_frame_start();
    int fs_cnt = 0;
    int fs_at = -1;
    jump(795, 524);
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (frame_start === 1'b1) begin fs_cnt++; fs_at = k; end
    end
    total++; if (fs_cnt != 1) begin bad++; $display("FAIL fs_wrap_count got=%0d want=1", fs_cnt); end
    total++; if (fs_at != 7) begin bad++; $display("FAIL fs_wrap_edge got=%0d want=7", fs_at); end
  endtask

  task automatic test_glyph();
    logic [11:0] want;
    jump(790, 18);
    for (int k = 1; k <= 35; k++) begin
      tick();
      if (k >= 12) begin
        want = ((k - 12) == 8 || (k - 12) == 15) ? FG : BG;
        total++;
        if (rgb !== want) begin
          bad++; $display("FAIL glyph_v19_h%0d got=%h want=%h", k - 12, rgb, want);
        end
      end
    end
    jump(636, 19);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k >= 2) begin
        want = ((634 + k) < 640) ? BG : 12'h000;
        total++;
        if (rgb !== want) begin
          bad++; $display("FAIL blank_v19_h%0d got=%h want=%h", 634 + k, rgb, want);
        end
      end
    end
  endtask

  task automatic test_cursor_blink();
    logic [11:0] want;
    reset = 1'b1;
    tick(); tick();
    cursor_en = 1'b1;
    cursor_x  = 7'd5;
    cursor_y  = 5'd2;
    reset = 1'b0;
    tick(); tick(); tick();
    for (int f = 0; f < 6; f++) begin
      for (int v = 45; v <= 47; v++) begin
        jump(36, v);
        for (int k = 1; k <= 14; k++) begin
          tick();
          if (k >= 2) begin
            want = ((f == 2 || f == 3) && v >= 46 && (34 + k) >= 40 && (34 + k) <= 47) ? FG : BG;
            total++;
            if (rgb !== want) begin
              bad++; $display("FAIL cursor_f%0d_v%0d_h%0d got=%h want=%h", f, v, 34 + k, rgb, want);
            end
          end
        end
      end
      jump(798, 524);
      tick(); tick(); tick();
    end
  endtask

  // Six frame wraps since reset leave the blink phase on.
  task automatic test_cursor_edge_column();
    logic [11:0] want;
    for (int pass = 0; pass < 2; pass++) begin
      cursor_x = (pass == 0) ? 7'd79 : 7'd80;
      jump(630, 46);
      for (int k = 1; k <= 24; k++) begin
        tick();
        if (k >= 2) begin
          if ((628 + k) >= 640) want = 12'h000;
          else if (pass == 0 && (628 + k) >= 632) want = FG;
          else want = BG;
          total++;
          if (rgb !== want) begin
            bad++; $display("FAIL cursor_x%0d_h%0d got=%h want=%h", cursor_x, 628 + k, rgb, want);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midline();
    int fs_cnt = 0;
    int fs_at = -1;
    int vs_low = 0;
    cursor_en = 1'b0;
    jump(300, 100);
    tick(); tick(); tick(); tick();
    total++; if (rgb !== BG) begin bad++; $display("FAIL midline_pre_rgb got=%h want=%h", rgb, BG); end
    reset = 1'b1;
    #1;
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL midline_async_rgb got=%h want=000", rgb); end
    total++; if (vga_hs !== 1'b1) begin bad++; $display("FAIL midline_async_hs got=%b want=1", vga_hs); end
    total++; if (vga_vs !== 1'b1) begin bad++; $display("FAIL midline_async_vs got=%b want=1", vga_vs); end
    total++; if (text_addr !== 12'd0) begin bad++; $display("FAIL midline_async_addr got=%0d want=0", text_addr); end
    tick(); tick(); tick();
    reset = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (frame_start === 1'b1) begin fs_cnt++; fs_at = n; end
      if (vga_vs === 1'b0) vs_low++;
      if (n == 17) begin
        total++;
        if (text_addr !== 12'd2) begin bad++; $display("FAIL midline_restart_addr got=%0d want=2", text_addr); end
      end
    end
    total++; if (fs_cnt != 1 || fs_at != 3) begin bad++; $display("FAIL midline_fs got=%0d@%0d want=1@3", fs_cnt, fs_at); end
    total++; if (vs_low != 0) begin bad++; $display("FAIL midline_vs got=%0d want=0", vs_low); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) text_mem[i] = 8'h00;
    text_mem[0]  = 8'h5A;
    text_mem[81] = 8'h41;
    test_reset();
    test_sync_timing();
    test_addressing();
    test_vsync();
    test_frame_start();
    test_glyph();
    test_cursor_blink();
    test_cursor_edge_column();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_text_renderer.md
Name: vga_text_renderer

Overview:
- 80x30 character text-mode renderer for a 640x480@60 Hz VGA output.
- Generates VGA timing and reads character codes from the text buffer.
- Forms the 12-bit glyph-row address {char[7:0], row[3:0]} for the font ROM (4096x8, combinational read) and serialises the returned 8-bit row into pixels.
- Adds a blinking underline cursor; sits between the text buffer and the VGA pins.

Parameters:
- FG_COLOR, 12'hFFF, foreground RGB444 {r,g,b}
- BG_COLOR, 12'h000, background RGB444
- BLINK_FRAMES, 30, frames per cursor blink phase (>=1)

Ports:
- clk  input  1  pixel clock, 25 MHz nominal
- reset  input  1  asynchronous, active-high
- io_cursor_x  input  7  cursor column 0..79
- io_cursor_y  input  5  cursor row 0..29
- io_cursor_en  input  1  cursor enable
- io_text_addr  output  12  text buffer address, row*80+col
- io_text_data  input  8  character code; synchronous read, valid 1 cycle after io_text_addr
- io_font_addr  output  12  font ROM address
- io_font_data  input  8  glyph row, combinational from io_font_addr, bit 7 = leftmost pixel
- io_vga_hs  output  1  hsync, active low
- io_vga_vs  output  1  vsync, active low
- io_vga_r / io_vga_g / io_vga_b  output  4 each  colour
- io_frame_start  output  1  one-cycle pulse, aligned with first visible pixel of a frame

Behaviour:
- Timing counters:
  - h: 0..799, wraps to 0.
  - v: 0..524, increments when h wraps; wraps to 0 at h=799, v=524.
  - Visible region: h<640 and v<480.
  - hsync low for h in 656..751; vsync low for v in 490..491.
- Pipeline, three positions:
  - S0: counters.
  - S1: one-cycle delayed copies of h[2:0], v[3:0], visible, hs, vs, cursor hit.
  - S2: registered outputs.
  - Total latency from counter value to pins is 2 cycles. hs, vs and blank travel through the same delay.
- S0 addressing:
  - io_text_addr = (v>>4)*80 + (h>>3) when visible, else 0. Combinational from counter registers only.
  - Maximum value 2399.
- S1:
  - io_font_addr = {io_text_data, v_d1[3:0]}.
  - pixel = io_font_data[7 - h_d1[2:0]].
- Cursor hit:
  - Condition: io_cursor_en, blink_phase=1, cell (h>>3, v>>4) equals (io_cursor_x, io_cursor_y), and v[3:0] in {14, 15}.
  - Evaluated at S0 and delayed to S1.
  - On a hit, pixel is inverted.
- S2 colour:
  - visible_d1 and pixel -> FG_COLOR.
  - visible_d1 and !pixel -> BG_COLOR.
  - Not visible -> 0.
- Cursor blink:
  - Frame counter increments at h=799, v=524.
  - On reaching BLINK_FRAMES-1 it clears and toggles blink_phase.
- io_frame_start: 1 for exactly one cycle when the S2 stage outputs the pixel of (h=0, v=0).
- Out-of-range cursor (x>79 or y>29): no hit, no other effect.
- Cursor inputs: sampled every cycle. A change mid-frame takes effect on the next pixel evaluated at S0.
- Reset, asynchronous, any time:
  - All counters to 0; blink_phase 0; all pipeline registers cleared.
  - io_vga_hs=1, io_vga_vs=1, rgb=0, io_frame_start=0.
  - io_text_addr=0; io_font_addr={io_text_data,4'h0}.
  - After deassertion, counting resumes from h=0, v=0 on the first clock edge.
- No handshake: the text buffer and font ROM must meet the stated latencies.

Test Plan:
- Reset release, run 800*525 cycles:
  - hs low exactly 96 cycles per line; first low on the 659th clock after release (h=656 plus 2 latency plus 1).
  - vs low 1600 cycles per frame.
  - io_frame_start pulses once per 420000 cycles.
- Text buffer model stores 8'h41 at address 81, font model returns 8'b1000_0001 for {8'h41, row 3}; observe line v=19 pixels h=8..15 -> FG, BG x6, FG. Other cells BG when the font returns 0.
- Addressing check: io_text_addr at h=639, v=479 equals 2399. At h=640 it equals 0. At h=799, v=479 it equals 0.
- Cursor, BLINK_FRAMES=2, io_cursor_en=1, x=5, y=2, all-zero font:
  - Frames 0-1: no FG.
  - Frames 2-3: pixels h=40..47 on lines v=46,47 are FG.
  - Frames 4-5: no FG.
- Cursor x=80: never FG in any frame.
- Assert reset mid-line at h=300, v=100 for 3 cycles:
  - Outputs go to reset values asynchronously, before the next edge.
  - After release, the next vs pulse arrives exactly 490 lines later.
